// File: rtl/kypd_scan_ctrl_if.sv
// kypd_scan_ctrl_if: key event handshake between the keypad scanner and its consumer.
// The master side owns code/release/valid; the slave side drives ready.
interface kypd_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_release;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code,
    output key_release,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_release,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/kypd_scan_ctrl.sv
// kypd_scan_ctrl: 4x4 keypad column scanner, frame debounce, 2-deep key event FIFO.
// Define KYPD_RELEASE_EVT_EN to also queue key-release events.
module kypd_scan_ctrl #(
  parameter int SCAN_CYCLES    = 100000,
  parameter int SETTLE_CYCLES  = 8,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       row,
  output logic [3:0]       col,
  kypd_scan_ctrl_if.master kb,
  output logic             key_held,
  output logic             overflow
);
  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] SETL = CW'(SETTLE_CYCLES);
  localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_SCANS);
`ifdef KYPD_RELEASE_EVT_EN
  localparam int EW = 5;
`else
  localparam int EW = 4;
`endif

  logic [3:0]      row_s1_q, row_s2_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      ci_q, ci_d;
  logic [3:0]      col_q, col_d;
  logic [3:0][3:0] samp_q, samp_d;
  logic [4:0]      cand_q, cand_d;
  logic [4:0]      stab_q, stab_d;
  logic [DW-1:0]   ccnt_q, ccnt_d;
  logic            held_q;
  logic [EW-1:0]   ent0_q, ent0_d;
  logic [EW-1:0]   ent1_q, ent1_d;
  logic [1:0]      fcnt_q, fcnt_d;
  logic            ovf_q, ovf_d;
`ifdef KYPD_RELEASE_EVT_EN
  logic            pend_q, pend_d;
  logic [3:0]      pend_code_q, pend_code_d;
`endif

  logic            frame_end;
  logic [4:0]      zeros;
  logic [3:0]      fcode;
  logic            ambig;
  logic [4:0]      res;
  logic            push;
  logic [EW-1:0]   push_ent;
  logic            valid;
  logic            pop;

  function automatic logic [3:0] key_map(
    input logic [1:0] c,
    input logic [1:0] r
  );
    logic [3:0] k;
    k = 4'h0;
    unique case ({c, r})
      4'h0: k = 4'h1;
      4'h1: k = 4'h4;
      4'h2: k = 4'h7;
      4'h3: k = 4'h0;
      4'h4: k = 4'h2;
      4'h5: k = 4'h5;
      4'h6: k = 4'h8;
      4'h7: k = 4'hF;
      4'h8: k = 4'h3;
      4'h9: k = 4'h6;
      4'hA: k = 4'h9;
      4'hB: k = 4'hE;
      4'hC: k = 4'hA;
      4'hD: k = 4'hB;
      4'hE: k = 4'hC;
      4'hF: k = 4'hD;
    endcase
    return k;
  endfunction

  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    ci_d   = ci_q;
    col_d  = col_q;
    samp_d = samp_q;
    if (cnt_q == LAST) begin
      cnt_d = '0;
      ci_d  = ci_q + 2'd1;
    end
    if (cnt_q == '0) begin
      unique case (ci_q)
        2'd0: col_d = 4'b0111;
        2'd1: col_d = 4'b1011;
        2'd2: col_d = 4'b1101;
        2'd3: col_d = 4'b1110;
      endcase
    end
    if (cnt_q == SETL) samp_d[ci_q] = row_s2_q;
  end

  // row bit b low in column slot c is key row r = 3-b
  always_comb begin
    zeros = 5'd0;
    fcode = 4'h0;
    for (int c = 0; c < 4; c++) begin
      for (int b = 0; b < 4; b++) begin
        if (!samp_q[c][b]) begin
          zeros = zeros + 5'd1;
          fcode = key_map(2'(c), 2'(3 - b));
        end
      end
    end
  end

  assign frame_end = (cnt_q == LAST) && (ci_q == 2'd3);
  assign ambig     = (zeros > 5'd1);
  assign res       = {zeros == 5'd1, fcode};

  always_comb begin
    cand_d   = cand_q;
    ccnt_d   = ccnt_q;
    stab_d   = stab_q;
    push     = 1'b0;
    push_ent = '0;
`ifdef KYPD_RELEASE_EVT_EN
    pend_d      = 1'b0;
    pend_code_d = pend_code_q;
    if (pend_q) begin
      push     = 1'b1;
      push_ent = {1'b0, pend_code_q};
    end
`endif
    if (frame_end) begin
      if (ambig) begin
        ccnt_d = '0;
      end else if (res == cand_q) begin
        if (ccnt_q != DMAX) ccnt_d = ccnt_q + DW'(1);
      end else begin
        cand_d = res;
        ccnt_d = DW'(1);
      end
      if (ccnt_d == DMAX && cand_d != stab_q) begin
        stab_d = cand_d;
`ifdef KYPD_RELEASE_EVT_EN
        if (stab_q[4]) begin
          push        = 1'b1;
          push_ent    = {1'b1, stab_q[3:0]};
          pend_d      = cand_d[4];
          pend_code_d = cand_d[3:0];
        end else if (cand_d[4]) begin
          push     = 1'b1;
          push_ent = {1'b0, cand_d[3:0]};
        end
`else
        if (cand_d[4]) begin
          push     = 1'b1;
          push_ent = cand_d[3:0];
        end
`endif
      end
    end
  end

  assign valid = (fcnt_q != 2'd0);
  assign pop   = valid && kb.key_ready;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    fcnt_d = fcnt_q;
    ovf_d  = ovf_q;
    case (fcnt_q)
      2'd0: begin
        if (push) begin
          ent0_d = push_ent;
          fcnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          ent0_d = push_ent;
        end else if (pop) begin
          fcnt_d = 2'd0;
        end else if (push) begin
          ent1_d = push_ent;
          fcnt_d = 2'd2;
        end
      end
      2'd2: begin
        if (pop) begin
          ent0_d = ent1_q;
          if (push) ent1_d = push_ent;
          else      fcnt_d = 2'd1;
        end else if (push) begin
          ovf_d = 1'b1;
        end
      end
      default: fcnt_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'hF;
      row_s2_q <= 4'hF;
      cnt_q    <= '0;
      ci_q     <= 2'd0;
      col_q    <= 4'hF;
      samp_q   <= {4{4'hF}};
      cand_q   <= 5'd0;
      stab_q   <= 5'd0;
      ccnt_q   <= '0;
      held_q   <= 1'b0;
      ent0_q   <= '0;
      ent1_q   <= '0;
      fcnt_q   <= 2'd0;
      ovf_q    <= 1'b0;
`ifdef KYPD_RELEASE_EVT_EN
      pend_q      <= 1'b0;
      pend_code_q <= 4'h0;
`endif
    end else begin
      row_s1_q <= row;
      row_s2_q <= row_s1_q;
      cnt_q    <= cnt_d;
      ci_q     <= ci_d;
      col_q    <= col_d;
      samp_q   <= samp_d;
      cand_q   <= cand_d;
      stab_q   <= stab_d;
      ccnt_q   <= ccnt_d;
      held_q   <= stab_d[4];
      ent0_q   <= ent0_d;
      ent1_q   <= ent1_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
`ifdef KYPD_RELEASE_EVT_EN
      pend_q      <= pend_d;
      pend_code_q <= pend_code_d;
`endif
    end
  end

  assign col         = col_q;
  assign key_held    = held_q;
  assign overflow    = ovf_q;
  assign kb.key_valid = valid;
  assign kb.key_code  = valid ? ent0_q[3:0] : 4'h0;
`ifdef KYPD_RELEASE_EVT_EN
  assign kb.key_release = valid & ent0_q[4];
`else
  assign kb.key_release = 1'b0;
`endif
endmodule
